// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control responder for the 5-stage CPU.
// Turns load-use stall requests, EX-stage branch redirects and the data
// memory wait handshake into per-stage register enables and flushes.
// Optional feature macro: PIPE_CTRL_PERF_EN adds a saturating counter of
// cycles in which the PC was held; without it stallCount reads as zero.
module pipe_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hazard,
    input  logic                 branchTaken,
    input  logic                 memReq,
    input  logic                 memReady,
    output logic                 pcEnable,
    output logic                 ifIdEnable,
    output logic                 ifIdFlush,
    output logic                 idExEnable,
    output logic                 idExFlush,
    output logic                 exMemEnable,
    output logic                 memWbEnable,
    output logic [CNT_WIDTH-1:0] stallCount
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOADUSE = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    // Control vector order: pc, ifId, idEx, exMem, memWb enables, ifIdFlush, idExFlush
    localparam logic [6:0] CTL_RUN     = 7'b1111100;
    localparam logic [6:0] CTL_FREEZE  = 7'b0000000;
    localparam logic [6:0] CTL_BRANCH  = 7'b1111111;
    localparam logic [6:0] CTL_LOADUSE = 7'b0011101;
    localparam logic [6:0] CTL_RESET   = 7'b0000011;

    // The hazard cycle itself is the first bubble, so the counter starts one lower
    localparam logic [2:0] BUBBLE_INIT = 3'(STALL_CYCLES - 1);

    state_t     state_q, state_d;
    state_t     eff_state;
    logic [2:0] bubble_q, bubble_d;
    logic       resume_q, resume_d;
    logic       freeze;
    logic [6:0] ctl;

    assign freeze = memReq && !memReady;

    // While waiting on memory, behave as the state that was active on entry
    always_comb begin
        eff_state = state_q;
        if (state_q == MEMWAIT) begin
            eff_state = resume_q ? LOADUSE : RUN;
        end
    end

    // Priority decode: freeze > branch > load-use > run; reset forces bubbles everywhere
    always_comb begin
        ctl      = CTL_RUN;
        state_d  = state_q;
        bubble_d = bubble_q;
        resume_d = resume_q;
        if (freeze) begin
            ctl      = CTL_FREEZE;
            state_d  = MEMWAIT;
            resume_d = (eff_state == LOADUSE);
        end else if (branchTaken) begin
            ctl      = CTL_BRANCH;
            state_d  = RUN;
            bubble_d = 3'd0;
            resume_d = 1'b0;
        end else if (eff_state == LOADUSE) begin
            ctl = CTL_LOADUSE;
            if (bubble_q <= 3'd1) begin
                state_d  = RUN;
                bubble_d = 3'd0;
            end else begin
                state_d  = LOADUSE;
                bubble_d = bubble_q - 3'd1;
            end
        end else if (hazard) begin
            ctl = CTL_LOADUSE;
            if (STALL_CYCLES <= 1) begin
                state_d = RUN;
            end else begin
                state_d  = LOADUSE;
                bubble_d = BUBBLE_INIT;
            end
        end else begin
            state_d = RUN;
        end
        if (reset) begin
            ctl = CTL_RESET;
        end
    end

    assign pcEnable    = ctl[6];
    assign ifIdEnable  = ctl[5];
    assign idExEnable  = ctl[4];
    assign exMemEnable = ctl[3];
    assign memWbEnable = ctl[2];
    assign ifIdFlush   = ctl[1];
    assign idExFlush   = ctl[0];

    // Control state registers; reset drops any pending bubbles or memory wait
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            bubble_q <= 3'd0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
            resume_q <= resume_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    // Count cycles where the PC is held, sticking at all-ones
    always_comb begin
        stall_count_d = stall_count_q;
        if (!pcEnable && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stallCount = stall_count_q;
`else
    assign stallCount = '0;
`endif

endmodule
